// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter for the shared single-port data RAM.
// The owner's access is routed straight to the RAM strobes; ack pulses the cycle after each access.
module ram_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          ack1,
  output logic          ram_ena,
  output logic          ram_write,
  output logic          ram_read,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

  // OWN0/OWN1 are one-hot so each grant is a flop output.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t        state;
  state_t        other_st;
  logic          prio;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          burst_done;

  logic          own_req;
  logic          own_we;
  logic [AW-1:0] own_addr;
  logic [DW-1:0] own_wdata;
  logic          other_req;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    if (c >= CNT_MAX) return CNT_MAX;
    return c + 1'b1;
  endfunction

  // Owner mux: the non-owner's inputs never reach the RAM.
  always_comb begin
    own_req   = 1'b0;
    own_we    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    other_req = 1'b0;
    other_st  = IDLE;
    case (state)
      OWN0: begin
        own_req   = req0;
        own_we    = we0;
        own_addr  = addr0;
        own_wdata = wdata0;
        other_req = req1;
        other_st  = OWN1;
      end
      OWN1: begin
        own_req   = req1;
        own_we    = we1;
        own_addr  = addr1;
        own_wdata = wdata1;
        other_req = req0;
        other_st  = OWN0;
      end
      default: ;
    endcase
  end

  assign ram_ena    = own_req;
  assign ram_write  = own_req & own_we;
  assign ram_read   = own_req & ~own_we;
  assign ram_addr   = own_req ? own_addr : '0;
  assign ram_wdata  = own_req ? own_wdata : '0;
  assign rdata      = ram_rdata;
  assign gnt0       = state[0];
  assign gnt1       = state[1];
  assign cnt_nxt    = sat_inc(cnt);
  assign burst_done = (cnt_nxt == CNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      prio  <= 1'b0;
      cnt   <= '0;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
    end else begin
      ack0 <= (state == OWN0) && req0;
      ack1 <= (state == OWN1) && req1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req0 && (!req1 || !prio)) state <= OWN0;
          else if (req1)                state <= OWN1;
        end
        OWN0, OWN1: begin
          if (!own_req) begin
            prio  <= (state == OWN0);
            cnt   <= '0;
            state <= other_req ? other_st : IDLE;
          end else if (other_req && burst_done) begin
            // Forced release: this cycle's access is the last of the burst.
            prio  <= (state == OWN0);
            cnt   <= '0;
            state <= other_st;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
